// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage RV32I core: load-use stalls, redirect flushes,
// external freeze and ECALL/EBREAK drain-to-halt, plus cycle/stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned DRAIN_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_we_reg,
  input  logic        ex_redirect,
  input  logic        ext_stall,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_nop,
  output logic        id_ex_we,
  output logic        id_ex_nop,
  output logic        ex_mem_nop,
  output logic        halted,
  output logic [31:0] cycle_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StHalted = 2'd2;

  localparam logic [1:0] DrainLoad = 2'(DRAIN_DEPTH - 1);
  localparam logic [6:0] OpSystem  = 7'b1110011;

  logic [1:0]  state_q, state_d;
  logic [1:0]  drain_cnt_q, drain_cnt_d;
  logic        halted_q;
  logic [31:0] cycle_q, stall_q, flush_q;
  logic        lu, sys, stall_inc, flush_inc;

  assign lu = ex_is_load & ex_we_reg & (ex_rd != 5'd0) &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign sys = (id_opcode == OpSystem);

  always_comb begin
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    if_id_nop   = 1'b0;
    id_ex_we    = 1'b0;
    id_ex_nop   = 1'b0;
    ex_mem_nop  = 1'b0;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (!rst) begin
      case (state_q)
        StRun: begin
          if (ext_stall) begin
            ex_mem_nop = 1'b1;
            stall_inc  = 1'b1;
          end else if (ex_redirect) begin
            // Wrong-path lu/sys are squashed along with the flushed stages.
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            if_id_nop = 1'b1;
            id_ex_we  = 1'b1;
            id_ex_nop = 1'b1;
            flush_inc = 1'b1;
          end else if (lu) begin
            id_ex_we  = 1'b1;
            id_ex_nop = 1'b1;
            stall_inc = 1'b1;
          end else if (sys) begin
            if_id_nop   = 1'b1;
            id_ex_we    = 1'b1;
            drain_cnt_d = DrainLoad;
            state_d     = StDrain;
          end else begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
            id_ex_we = 1'b1;
          end
        end
        StDrain: begin
          if (ext_stall) begin
            ex_mem_nop = 1'b1;
            stall_inc  = 1'b1;
          end else begin
            if_id_nop = 1'b1;
            id_ex_nop = 1'b1;
            if (drain_cnt_q == 2'd0) state_d = StHalted;
            else                     drain_cnt_d = drain_cnt_q - 2'd1;
          end
        end
        StHalted: begin
          if_id_nop  = 1'b1;
          id_ex_nop  = 1'b1;
          ex_mem_nop = 1'b1;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      drain_cnt_q <= 2'd0;
      halted_q    <= 1'b0;
      cycle_q     <= 32'd0;
      stall_q     <= 32'd0;
      flush_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= (state_d == StHalted);
      if (state_q != StHalted) cycle_q <= cycle_q + 32'd1;
      if (stall_inc)           stall_q <= stall_q + 32'd1;
      if (flush_inc)           flush_q <= flush_q + 32'd1;
    end
  end

  assign halted    = halted_q;
  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: load-use, redirect, freeze, drain/halt and reset.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_we_reg, ex_redirect, ext_stall;
  logic        pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop, ex_mem_nop, halted;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_DEPTH(3)) dut (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_we_reg(ex_we_reg),
    .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_nop(if_id_nop),
    .id_ex_we(id_ex_we), .id_ex_nop(id_ex_nop), .ex_mem_nop(ex_mem_nop),
    .halted(halted), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs may be changed right after, then settle before checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    id_opcode   = 7'h13;
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0;
    ex_rd       = 5'd0;
    ex_is_load  = 1'b0;
    ex_we_reg   = 1'b0;
    ex_redirect = 1'b0;
    ext_stall   = 1'b0;
  endtask

  task automatic load_use_rs1();
    ex_rd = 5'd5; ex_is_load = 1'b1; ex_we_reg = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  // Leaves the bench at cycle 0: first non-reset cycle.
  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    // Reset values and reset-time outputs
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
    chk("rst_if_id_we", {31'd0, if_id_we}, 32'd0);
    chk("rst_id_ex_we", {31'd0, id_ex_we}, 32'd0);
    chk("rst_nops", {29'd0, if_id_nop, id_ex_nop, ex_mem_nop}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flush", flush_cnt, 32'd0);
    rst = 1'b0;
    settle();
    chk("run_enables", {29'd0, pc_we, if_id_we, id_ex_we}, 32'h7);

    // Load-use on rs1
    load_use_rs1();
    settle();
    chk("lu_pc_we", {31'd0, pc_we}, 32'd0);
    chk("lu_if_id_we", {31'd0, if_id_we}, 32'd0);
    chk("lu_id_ex_nop", {31'd0, id_ex_nop}, 32'd1);
    chk("lu_stall_before", stall_cnt, 32'd0);
    tick();
    idle();
    settle();
    chk("lu_stall_after", stall_cnt, 32'd1);
    chk("lu_next_enables", {29'd0, pc_we, if_id_we, id_ex_we}, 32'h7);
    chk("lu_next_nop", {31'd0, id_ex_nop}, 32'd0);

    // No false stall: ex_rd = x0
    load_use_rs1();
    ex_rd = 5'd0; id_rs1 = 5'd0;
    settle();
    chk("x0_pc_we", {31'd0, pc_we}, 32'd1);
    chk("x0_id_ex_nop", {31'd0, id_ex_nop}, 32'd0);
    tick();
    // No false stall: rs1 matches but not used
    idle();
    load_use_rs1();
    id_uses_rs1 = 1'b0;
    settle();
    chk("unused_pc_we", {31'd0, pc_we}, 32'd1);
    tick();
    chk("nofalse_stall_cnt", stall_cnt, 32'd1);
    // Load-use through rs2
    idle();
    ex_rd = 5'd9; ex_is_load = 1'b1; ex_we_reg = 1'b1; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
    settle();
    chk("lu_rs2_pc_we", {31'd0, pc_we}, 32'd0);
    tick();
    idle();
    settle();
    chk("lu_rs2_stall_cnt", stall_cnt, 32'd2);

    // Redirect with simultaneous load-use
    do_reset();
    load_use_rs1();
    ex_redirect = 1'b1;
    settle();
    chk("redir_pc_we", {31'd0, pc_we}, 32'd1);
    chk("redir_nops", {30'd0, if_id_nop, id_ex_nop}, 32'h3);
    chk("redir_ex_mem_nop", {31'd0, ex_mem_nop}, 32'd0);
    tick();
    chk("redir_flush_cnt", flush_cnt, 32'd1);
    chk("redir_stall_cnt", stall_cnt, 32'd0);
    // Freeze beats redirect
    idle();
    ex_redirect = 1'b1;
    ext_stall   = 1'b1;
    settle();
    chk("frz_enables", {29'd0, pc_we, if_id_we, id_ex_we}, 32'd0);
    chk("frz_nops", {29'd0, if_id_nop, id_ex_nop, ex_mem_nop}, 32'h1);
    tick();
    ext_stall = 1'b0;
    settle();
    chk("frz_stall_cnt", stall_cnt, 32'd1);
    chk("frz_flush_cnt", flush_cnt, 32'd1);
    chk("frz_redir_serviced", {30'd0, pc_we, if_id_nop}, 32'h3);
    tick();
    chk("frz_flush_cnt2", flush_cnt, 32'd2);

    // ECALL at cycle 10, redirect pulse at cycle 12 ignored
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    id_opcode = 7'h73;
    settle();
    chk("ecall_pc_we", {31'd0, pc_we}, 32'd0);
    chk("ecall_ctl", {29'd0, if_id_nop, id_ex_we, id_ex_nop}, 32'h6);
    tick();
    idle();
    settle();
    chk("drain11_ctl", {28'd0, pc_we, if_id_we, if_id_nop, id_ex_nop}, 32'h3);
    tick();
    ex_redirect = 1'b1;
    settle();
    chk("drain12_redir_pc_we", {31'd0, pc_we}, 32'd0);
    tick();
    idle();
    settle();
    chk("drain13_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("halt14_halted", {31'd0, halted}, 32'd1);
    chk("halt14_cycle", cycle_cnt, 32'd14);
    chk("halt14_flush", flush_cnt, 32'd0);
    chk("halt14_nops", {29'd0, if_id_nop, id_ex_nop, ex_mem_nop}, 32'h7);
    ex_redirect = 1'b1;
    settle();
    chk("halt_redir_pc_we", {31'd0, pc_we}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("halt_cycle_frozen", cycle_cnt, 32'd14);
    chk("halt_still", {31'd0, halted}, 32'd1);

    // ECALL at cycle 10, freeze at cycles 11 and 12
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    id_opcode = 7'h73;
    tick();
    idle();
    ext_stall = 1'b1;
    settle();
    chk("dstall11_ex_mem_nop", {31'd0, ex_mem_nop}, 32'd1);
    tick();
    settle();
    chk("dstall12_ex_mem_nop", {31'd0, ex_mem_nop}, 32'd1);
    tick();
    ext_stall = 1'b0;
    settle();
    chk("dstall13_ex_mem_nop", {31'd0, ex_mem_nop}, 32'd0);
    tick();
    tick();
    chk("dstall15_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("dstall16_halted", {31'd0, halted}, 32'd1);
    chk("dstall_stall_cnt", stall_cnt, 32'd2);
    chk("dstall_cycle_cnt", cycle_cnt, 32'd16);

    // Reset at cycle 12 mid-drain
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    id_opcode = 7'h73;
    tick();
    idle();
    tick();
    rst = 1'b1;
    settle();
    chk("rst_mid_pc_we", {31'd0, pc_we}, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("rst13_halted", {31'd0, halted}, 32'd0);
    chk("rst13_counters", cycle_cnt | stall_cnt | flush_cnt, 32'd0);
    chk("rst13_pc_we", {31'd0, pc_we}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("rst16_halted", {31'd0, halted}, 32'd0);
    chk("rst16_cycle", cycle_cnt, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central pipeline controller for the five-stage RV32I core. Each cycle it drives the write-enable and bubble/flush (`nop`) controls of the PC, IF/ID, ID/EX and EX/MEM stage registers. It detects load-use hazards, applies branch/jump redirect flushes, honours an external freeze request, and drains the pipeline to a halted state on ECALL/EBREAK. It also keeps 32-bit cycle, stall and flush performance counters. It sits beside the datapath and reads decode-stage and ID/EX-stage fields.

## Interface
- `DRAIN_DEPTH`, default 3: cycles from ECALL/EBREAK leaving ID until it retires (EX, MEM, WB).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `id_opcode`  in  7  opcode of the instruction in ID.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  the ID instruction actually reads that source.
- `ex_rd`  in  5  ID/EX destination register.
- `ex_is_load`, `ex_we_reg`  in  1 each  ID/EX load flag and register-write flag.
- `ex_redirect`  in  1  branch taken or jump resolved in EX; PC target is valid this cycle.
- `ext_stall`  in  1  external freeze request (debug, slow memory).
- `pc_we`  out  1  PC register load enable.
- `if_id_we`, `if_id_nop`  out  1 each  IF/ID controls. `we=1, nop=0` loads; `nop=1` flushes to 0x00000013; `we=0, nop=0` holds.
- `id_ex_we`, `id_ex_nop`  out  1 each  ID/EX controls, same encoding.
- `ex_mem_nop`  out  1  EX/MEM bubble; clears write/load enables.
- `halted`  out  1  the pipeline has drained after ECALL/EBREAK.
- `cycle_cnt`, `stall_cnt`, `flush_cnt`  out  32 each  performance counters.

## Operation
- FSM states: RUN, DRAIN, HALTED. `drain_cnt` is 2 bits wide.
- Load-use hazard (`lu`): `ex_is_load & ex_we_reg & ex_rd != 0` and (`id_uses_rs1 & id_rs1 == ex_rd` or `id_uses_rs2 & id_rs2 == ex_rd`).
- System instruction (`sys`): `id_opcode == 7'b1110011`.
- RUN priority per cycle, highest first:
  - `ext_stall`: `pc_we`, `if_id_we`, `id_ex_we` = 0; `if_id_nop`, `id_ex_nop` = 0 (hold); `ex_mem_nop` = 1; `stall_cnt++`.
  - `ex_redirect`: `pc_we` = 1; `if_id_nop` = 1; `id_ex_nop` = 1; `flush_cnt++`. Any `lu` or `sys` in this cycle is ignored because it is on the wrong path.
  - `lu`: `pc_we` = 0; `if_id_we` = 0; `id_ex_nop` = 1; `stall_cnt++`. Exactly one bubble is inserted; the next cycle sees the bubble in ID/EX, so `lu` deasserts.
  - `sys`: `pc_we` = 0; `if_id_nop` = 1; `id_ex_we` = 1 (the system instruction advances to EX). Load `drain_cnt` = `DRAIN_DEPTH`-1 and go to DRAIN.
  - Otherwise: `pc_we`, `if_id_we`, `id_ex_we` = 1; all nops = 0.
- DRAIN:
  - Outputs: `pc_we` = 0; `if_id_we` = 0; `if_id_nop` = 1; `id_ex_nop` = 1; `ex_mem_nop` = 0.
  - `ex_redirect`, `lu` and `sys` are ignored.
  - With `ext_stall`: the ext_stall outputs apply, `drain_cnt` holds, and `stall_cnt++`.
  - Otherwise: if `drain_cnt` == 0, go to HALTED; else decrement `drain_cnt`.
- HALTED:
  - `pc_we`, `if_id_we`, `id_ex_we` = 0; `if_id_nop`, `id_ex_nop`, `ex_mem_nop` = 1; `halted` = 1.
  - All inputs are ignored. The only exit is `rst`.
- Counters:
  - `cycle_cnt` increments on every non-reset cycle not in HALTED.
  - All counters wrap modulo 2^32 with no saturation.
- Outputs are combinational from state plus inputs (Mealy). The counters and `halted` are registered.

## Timing
- While `rst` = 1: state = RUN; `drain_cnt` = 0; all counters = 0; `halted` = 0.
- While `rst` = 1 the outputs are: `pc_we`, `if_id_we`, `id_ex_we` = 0; all nops = 0.
- `rst` asserted mid-DRAIN or in HALTED returns the block to RUN on the next edge. Counters clear on the same edge.
- Stall/flush outputs take effect in the same cycle as the hazard. There is zero added latency.
- Counters update on the clock edge that ends the qualifying cycle, so they are visible the following cycle.
- If `sys` is in ID at cycle T with no stalls, the FSM is in DRAIN at T+1..T+3 and `halted` = 1 from T+4. Each `ext_stall` cycle during DRAIN adds one cycle.
- `ext_stall` asserted together with `ex_redirect`: the freeze wins. The redirect stays asserted because ID/EX holds, and it is serviced on the first unstalled cycle.

## Test plan
- Load-use: `ex_rd`=5, `ex_is_load`=1, `ex_we_reg`=1, `id_rs1`=5, `id_uses_rs1`=1 -> one cycle with `pc_we`=0, `if_id_we`=0, `id_ex_nop`=1; `stall_cnt` 0→1; next cycle all enables = 1.
- No false stall: same as above with `ex_rd`=0, or with `id_uses_rs1`=0 -> `pc_we`=1, `id_ex_nop`=0, `stall_cnt` unchanged.
- Redirect plus load-use in the same cycle -> `pc_we`=1, `if_id_nop`=1, `id_ex_nop`=1; `flush_cnt`=1; `stall_cnt`=0.
- ECALL (0x00000073) in ID at cycle 10 -> `pc_we`=0 from cycle 10; `halted`=1 at cycle 14; `cycle_cnt` frozen at 14 thereafter; `ex_redirect` pulsed at cycle 12 is ignored.
- `ext_stall` for 2 cycles during DRAIN, ECALL at cycle 10 -> `halted` at cycle 16; `ex_mem_nop`=1 in both stall cycles; `stall_cnt`=2.
- `rst` at cycle 12 mid-DRAIN -> at cycle 13: state RUN, `halted`=0, all counters 0, `pc_we`=1.
